// File: rtl/mnist_frame_sequencer.sv
// mnist_frame_sequencer: streams images from pixel/label RAMs into mnist_cnn and grades each decision.
module mnist_frame_sequencer #(
  parameter int PIXELS = 784,
  parameter int ADDR_W = 17,
  parameter int RST_CYC = 2,
  parameter int WAIT_MAX = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [9:0]        num_img,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [9:0]        lbl_addr,
  input  logic [3:0]        lbl_data,
  output logic              cnn_rst,
  output logic [7:0]        pixel,
  output logic              pixel_strobe,
  input  logic [3:0]        decision,
  input  logic              valid_out,
  output logic              result_valid,
  output logic [9:0]        result_idx,
  output logic [3:0]        result_dec,
  output logic              result_hit,
  output logic [9:0]        correct_cnt,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);
  localparam int CW = $clog2(WAIT_MAX + PIXELS + RST_CYC + 2);
  typedef enum logic [2:0] {IDLE, CRST, STREAM, WAIT, REPORT, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [9:0] num_q, img_idx;
  logic [3:0] lbl_q, dec_q;
  logic rd_d, go, crst_end, stream_end, wait_end;
  assign go = start && !abort && (state == IDLE || state == DONE);
  assign crst_end = cnt == CW'(RST_CYC - 1);
  assign stream_end = cnt == CW'(PIXELS + 1);
  assign wait_end = cnt == CW'(WAIT_MAX - 1);
  assign lbl_addr = img_idx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (go) nxt = num_img == '0 ? DONE : CRST;
      CRST: if (crst_end) nxt = STREAM;
      STREAM: if (stream_end) nxt = WAIT;
      WAIT: if (valid_out || wait_end) nxt = REPORT;
      REPORT: nxt = img_idx + 10'd1 == num_q ? DONE : CRST;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
    mem_rd = state == STREAM && cnt < CW'(PIXELS);
    cnn_rst = !(state == STREAM || state == WAIT);
    result_valid = state == REPORT;
    result_idx = result_valid ? img_idx : '0;
    result_dec = result_valid ? dec_q : '0;
    result_hit = result_valid && dec_q == lbl_q;
    busy = !(state == IDLE || state == DONE);
    done = state == DONE;
  end
  // pixel data returns one cycle after the read and is registered once more, so strobe trails reads by two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      num_q <= '0;
      img_idx <= '0;
      lbl_q <= '0;
      dec_q <= '0;
      rd_d <= 1'b0;
      pixel_strobe <= 1'b0;
      pixel <= '0;
      mem_addr <= '0;
      correct_cnt <= '0;
      err <= '0;
    end else begin
      cnt <= nxt == state ? cnt + CW'(1) : '0;
      rd_d <= mem_rd && !abort;
      pixel_strobe <= rd_d && !abort;
      if (rd_d) pixel <= mem_data;
      if (state == CRST && crst_end) lbl_q <= lbl_data;
      if (state == WAIT) dec_q <= valid_out ? decision : 4'hF;
      if (go) begin
        num_q <= num_img;
        img_idx <= '0;
        correct_cnt <= '0;
        err <= '0;
        mem_addr <= '0;
      end else if (!abort) begin
        if (mem_rd) mem_addr <= mem_addr + ADDR_W'(1);
        if (state == WAIT && wait_end && !valid_out) err[0] <= 1'b1;
        if ((state == CRST || state == STREAM) && valid_out) err[1] <= 1'b1;
        if (state == REPORT) begin
          img_idx <= img_idx + 10'd1;
          correct_cnt <= correct_cnt + 10'(result_hit);
        end
      end
    end
  end
endmodule

// File: tb/tb_mnist_frame_sequencer.sv
// tb_mnist_frame_sequencer: memory/core models plus an event-level scoreboard for the frame sequencer.
module tb_mnist_frame_sequencer;
  localparam int PIXELS = 784, ADDR_W = 17, RST_CYC = 2, WAIT_MAX = 4096;
  logic clk = 0, rst = 0, start = 0, abort = 0, valid_out = 0;
  logic [9:0] num_img = 0;
  logic [7:0] mem_data = 0;
  logic [3:0] lbl_data = 0, decision = 0;
  logic mem_rd, cnn_rst, pixel_strobe, result_valid, result_hit, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [9:0] lbl_addr, result_idx, correct_cnt;
  logic [7:0] pixel;
  logic [3:0] result_dec;
  logic [1:0] err;

  mnist_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_img(num_img),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .lbl_addr(lbl_addr), .lbl_data(lbl_data), .cnn_rst(cnn_rst),
    .pixel(pixel), .pixel_strobe(pixel_strobe), .decision(decision), .valid_out(valid_out),
    .result_valid(result_valid), .result_idx(result_idx), .result_dec(result_dec),
    .result_hit(result_hit), .correct_cnt(correct_cnt), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int a);
    return 8'((a * 37) ^ (a >> 5));
  endfunction

  // pixel and label RAMs: data appears the cycle after the address
  logic [3:0] lbl_tab[1024];
  always begin
    logic r;
    logic [ADDR_W-1:0] a;
    logic [9:0] la;
    @(negedge clk);
    r = mem_rd;
    a = mem_addr;
    la = lbl_addr;
    @(posedge clk);
    #1;
    mem_data = r ? pix(int'(a)) : 8'hEE;
    lbl_data = lbl_tab[la];
  end

  // core model: answers 50 cycles after the last pixel, optional early pulse at pixel 400
  logic [3:0] dec_tab[4];
  int n_st = 0, dly = 0, core_img = 0;
  bit core_on = 1, early_en = 0;
  always begin
    logic cr, ps;
    @(negedge clk);
    cr = cnn_rst;
    ps = pixel_strobe;
    @(posedge clk);
    #1;
    valid_out = 0;
    if (!rst || cr) begin
      n_st = 0;
      dly = 0;
    end else begin
      if (ps) begin
        if (early_en && n_st == 400) begin
          valid_out = 1;
          decision = 4'hA;
        end
        if (core_on && n_st == PIXELS - 1) dly = 50;
        n_st++;
      end
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          valid_out = 1;
          decision = dec_tab[core_img % 4];
          core_img++;
        end
      end
    end
  end

  typedef struct {int idx; int dec; bit hit; bit tmo;} res_t;
  res_t exp_q[$];
  res_t e;
  int exp_addr = 0, exp_pix = 0, run_len = 0, st_len = 0, hi_len = 0, exp_cnt = 0, rd_total = 0;
  int last_rd = 0, last_vo = 0, res_cyc = 0, n_img = 0;
  int rd_cyc[4096];
  int img_cyc[8], img_addr[8];
  bit chk_en = 0, abort_pend = 0;

  always @(negedge clk) if (rst && chk_en) begin
    if (abort_pend) begin
      chk("abort_mem_rd", mem_rd, 0);
      chk("abort_cnn_rst", cnn_rst, 1);
      chk("abort_strobe", pixel_strobe, 0);
      chk("abort_busy", busy, 0);
      run_len = 0;
      st_len = 0;
      abort_pend = 0;
    end
    if (abort) abort_pend = 1;
    chk("correct_cnt", correct_cnt, exp_cnt);
    if (mem_rd) begin
      chk("rd_addr", mem_addr, exp_addr);
      chk("rd_cnn_rst", cnn_rst, 0);
      if (run_len == 0) begin
        chk("cnn_rst_gap", hi_len >= RST_CYC, 1);
        img_cyc[n_img % 8] = cyc;
        img_addr[n_img % 8] = exp_addr;
        n_img++;
      end
      rd_cyc[exp_addr % 4096] = cyc;
      last_rd = cyc;
      exp_addr++;
      run_len++;
      rd_total++;
    end else if (run_len != 0) begin
      chk("rd_run_len", run_len, PIXELS);
      run_len = 0;
    end
    hi_len = cnn_rst ? hi_len + 1 : 0;
    if (pixel_strobe) begin
      chk("pixel", pixel, pix(exp_pix));
      chk("pixel_latency", cyc - rd_cyc[exp_pix % 4096], 2);
      exp_pix++;
      st_len++;
    end else if (st_len != 0) begin
      chk("strobe_len", st_len, PIXELS);
      st_len = 0;
    end
    if (valid_out) last_vo = cyc;
    if (result_valid) begin
      res_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got result_valid=1 idx %0d, expected none", result_idx);
      end else begin
        e = exp_q.pop_front();
        chk("result_idx", result_idx, e.idx);
        chk("result_dec", result_dec, e.dec);
        chk("result_hit", result_hit, e.hit);
        chk("result_time", cyc, e.tmo ? last_rd + WAIT_MAX + 3 : last_vo + 1);
        exp_cnt += e.hit;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    num_img = 10'(n);
    start = 1;
    tick();
    start = 0;
    exp_cnt = 0;
    exp_addr = 0;
    exp_pix = 0;
    core_img = 0;
    n_img = 0;
  endtask

  task automatic wait_done(input string t, input int lim);
    for (int i = 0; i < lim && !done; i++) tick();
    chk({t, "_done"}, done, 1);
    chk({t, "_results_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_addr(input string t, input int a);
    int i;
    for (i = 0; i < 5000 && !(mem_rd && mem_addr == ADDR_W'(a)); i++) tick();
    chk({t, "_reached_addr"}, i < 5000, 1);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_mem_rd"}, mem_rd, 0);
    chk({t, "_mem_addr"}, mem_addr, 0);
    chk({t, "_lbl_addr"}, lbl_addr, 0);
    chk({t, "_cnn_rst"}, cnn_rst, 1);
    chk({t, "_pixel"}, pixel, 0);
    chk({t, "_strobe"}, pixel_strobe, 0);
    chk({t, "_rvalid"}, result_valid, 0);
    chk({t, "_ridx"}, result_idx, 0);
    chk({t, "_rdec"}, result_dec, 0);
    chk({t, "_rhit"}, result_hit, 0);
    chk({t, "_cnt"}, correct_cnt, 0);
    chk({t, "_err"}, err, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    for (int i = 0; i < 1024; i++) lbl_tab[i] = 0;
    for (int i = 0; i < 4; i++) dec_tab[i] = 0;
    repeat (3) tick();
    chk_reset("reset");
    rst = 1;
    tick();
    chk_en = 1;
    // one image, decision matches label
    lbl_tab[0] = 7; dec_tab[0] = 7;
    exp_q.push_back('{0, 7, 1, 0});
    run(1);
    chk("s1_busy", busy, 1);
    wait_done("s1", 2000);
    chk("s1_cnt", correct_cnt, 1);
    chk("s1_reads", exp_addr, 784);
    chk("s1_result_cycle", res_cyc - img_cyc[0], 836);
    chk("s1_err", err, 0);
    // three images, middle one misgraded, stray start mid-run
    lbl_tab[0] = 3; lbl_tab[1] = 5; lbl_tab[2] = 9;
    dec_tab[0] = 3; dec_tab[1] = 2; dec_tab[2] = 9;
    exp_q.push_back('{0, 3, 1, 0});
    exp_q.push_back('{1, 2, 0, 0});
    exp_q.push_back('{2, 9, 1, 0});
    run(3);
    repeat (100) tick();
    num_img = 0; start = 1;
    tick();
    start = 0;
    chk("s2_busy_after_stray_start", busy, 1);
    wait_done("s2", 4000);
    chk("s2_cnt", correct_cnt, 2);
    chk("s2_images", n_img, 3);
    chk("s2_addr1", img_addr[1], 784);
    chk("s2_addr2", img_addr[2], 1568);
    chk("s2_period1", img_cyc[1] - img_cyc[0], 839);
    chk("s2_period2", img_cyc[2] - img_cyc[1], 839);
    // silent core: both images time out
    core_on = 0;
    exp_q.push_back('{0, 15, 0, 1});
    exp_q.push_back('{1, 15, 0, 1});
    run(2);
    wait_done("s3", 12000);
    chk("s3_cnt", correct_cnt, 0);
    chk("s3_err", err, 1);
    core_on = 1;
    // early valid_out mid-stream, later result graded normally
    lbl_tab[0] = 4; dec_tab[0] = 4; early_en = 1;
    exp_q.push_back('{0, 4, 1, 0});
    r0 = rd_total;
    run(1);
    wait_done("s4", 2000);
    early_en = 0;
    chk("s4_err", err, 2);
    chk("s4_cnt", correct_cnt, 1);
    chk("s4_reads", rd_total - r0, 784);
    // abort during the second image of three
    lbl_tab[0] = 3; dec_tab[0] = 3;
    exp_q.push_back('{0, 3, 1, 0});
    run(3);
    wait_addr("s5", 884);
    abort = 1;
    exp_q.delete();
    tick();
    abort = 0;
    chk("s5_busy", busy, 0);
    chk("s5_mem_rd", mem_rd, 0);
    chk("s5_cnn_rst", cnn_rst, 1);
    chk("s5_rvalid", result_valid, 0);
    chk("s5_cnt_held", correct_cnt, 1);
    chk("s5_addr_held", mem_addr, 884);
    repeat (20) tick();
    lbl_tab[0] = 6; dec_tab[0] = 6;
    exp_q.push_back('{0, 6, 1, 0});
    run(1);
    chk("s5_cnt_clr", correct_cnt, 0);
    wait_done("s5", 2000);
    chk("s5_restart_addr", img_addr[0], 0);
    chk("s5_restart_cnt", correct_cnt, 1);
    // zero images
    abort = 1;
    tick();
    abort = 0;
    chk("s6_idle_done", done, 0);
    r0 = rd_total;
    run(0);
    chk("s6_done", done, 1);
    chk("s6_busy", busy, 0);
    repeat (5) tick();
    chk("s6_no_reads", rd_total - r0, 0);
    // async reset mid-stream
    lbl_tab[0] = 2; dec_tab[0] = 2;
    exp_q.push_back('{0, 2, 1, 0});
    run(1);
    wait_addr("s7", 300);
    #1;
    rst = 0;
    #1;
    chk_reset("s7");
    exp_q.delete();
    run_len = 0; st_len = 0; exp_cnt = 0; abort_pend = 0;
    tick();
    tick();
    rst = 1;
    tick();
    chk("s7_idle_busy", busy, 0);
    chk("s7_idle_cnn_rst", cnn_rst, 1);
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
